// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence-detector stimulus path.
// Holds the transmitter FSM state encoding, the reference 110 pattern and default widths.
package seq_pkg;

    localparam int SEQ_PAT_W = 3;
    localparam int SEQ_CNT_W = 8;

    localparam logic [2:0] PAT_110 = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register feeding the serial pattern stream.
// Load has priority over shift; vacated LSBs fill with zero.
module seq_piso #(
    parameter int PAT_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] din,
    output logic [PAT_W-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[PAT_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_gen_pattern_tx.sv
// Serial pattern transmitter: repeats a latched PAT_W-bit pattern MSB-first,
// optionally separated by idle gaps, then pulses done. All outputs are registered.
module seq_gen_pattern_tx
    import seq_pkg::*;
#(
    parameter int               PAT_W   = SEQ_PAT_W,
    parameter int               CNT_W   = SEQ_CNT_W,
    parameter logic [PAT_W-1:0] PAT_DEF = PAT_W'(PAT_110)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             use_def,
    input  logic [PAT_W-1:0] pat,
    input  logic [CNT_W-1:0] reps,
    input  logic [CNT_W-1:0] gap,
    output logic             out,
    output logic             out_valid,
    output logic             first,
    output logic             busy,
    output logic             done
);

    localparam int                IDX_W    = $clog2(PAT_W);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PAT_W - 1);

    seq_state_t       state;
    logic [IDX_W-1:0] bit_idx;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] gap_lat;
    logic [CNT_W-1:0] gap_cnt;
    logic [PAT_W-1:0] pat_lat;
    logic [PAT_W-1:0] sh_q;

    logic [PAT_W-1:0] pat_sel;
    logic [PAT_W-1:0] load_data;
    logic [CNT_W-1:0] rem_dec;
    logic             last_bit;
    logic             gap_end;
    logic             load;
    logic             shift;

    // The shift register only sees load/shift; which pattern it loads and when
    // is decided here so the registered out can be driven in the same edge.
    always_comb begin
        pat_sel   = use_def ? PAT_DEF : pat;
        rem_dec   = (remaining == '0) ? '0 : remaining - 1'b1;
        last_bit  = (bit_idx == '0);
        gap_end   = (gap_cnt <= CNT_W'(1));
        load      = 1'b0;
        shift     = 1'b0;
        load_data = pat_lat;
        case (state)
            ST_IDLE: begin
                if (start && reps != '0) begin
                    load      = 1'b1;
                    load_data = pat_sel;
                end
            end
            ST_SEND: begin
                if (!last_bit) begin
                    shift = 1'b1;
                end else if (rem_dec != '0 && gap_lat == '0) begin
                    load = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_end) begin
                    load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    seq_piso #(.PAT_W(PAT_W)) u_piso (
        .clk   (clk),
        .rstn  (rstn),
        .load  (load),
        .shift (shift),
        .din   (load_data),
        .q     (sh_q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            bit_idx   <= '0;
            remaining <= '0;
            gap_lat   <= '0;
            gap_cnt   <= '0;
            pat_lat   <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            first     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            out       <= 1'b0;
            out_valid <= 1'b0;
            first     <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pat_lat   <= pat_sel;
                        gap_lat   <= gap;
                        remaining <= reps;
                        busy      <= 1'b1;
                        if (reps != '0) begin
                            state     <= ST_SEND;
                            bit_idx   <= IDX_LAST;
                            out       <= pat_sel[PAT_W-1];
                            out_valid <= 1'b1;
                            first     <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (!last_bit) begin
                        bit_idx   <= bit_idx - 1'b1;
                        out       <= sh_q[PAT_W-2];
                        out_valid <= 1'b1;
                    end else begin
                        remaining <= rem_dec;
                        if (rem_dec == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else if (gap_lat != '0) begin
                            state   <= ST_GAP;
                            gap_cnt <= gap_lat;
                        end else begin
                            // Seamless repeat: next MSB follows the last bit directly.
                            bit_idx   <= IDX_LAST;
                            out       <= pat_lat[PAT_W-1];
                            out_valid <= 1'b1;
                            first     <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_end) begin
                        gap_cnt   <= '0;
                        state     <= ST_SEND;
                        bit_idx   <= IDX_LAST;
                        out       <= pat_lat[PAT_W-1];
                        out_valid <= 1'b1;
                        first     <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen_pattern_tx.sv
// Directed bench for seq_gen_pattern_tx: per-cycle expected output vectors are
// queued when a transfer is launched and popped/compared on each falling edge.
module tb_seq_gen_pattern_tx;

    localparam int PAT_W = 3;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic             use_def = 1'b0;
    logic [PAT_W-1:0] pat = '0;
    logic [CNT_W-1:0] reps = '0;
    logic [CNT_W-1:0] gap = '0;
    logic             out;
    logic             out_valid;
    logic             first;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    // Vector layout: {out_valid, out, first, done, busy}
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    seq_gen_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .use_def   (use_def),
        .pat       (pat),
        .reps      (reps),
        .gap       (gap),
        .out       (out),
        .out_valid (out_valid),
        .first     (first),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Build the expected cycle stream from first bit through the idle cycle after done.
    task automatic launch(input logic ud, input logic [PAT_W-1:0] p,
                          input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] g);
        logic [PAT_W-1:0] ep;
        ep = ud ? 3'b110 : p;
        for (int i = 0; i < int'(r); i++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                exp_q.push_back({1'b1, ep[b], (b == PAT_W - 1), 1'b0, 1'b1});
            if (i < int'(r) - 1)
                for (int j = 0; j < int'(g); j++) exp_q.push_back(5'b00001);
        end
        exp_q.push_back(5'b00011);
        exp_q.push_back(5'b00000);
        use_def = ud;
        pat     = p;
        reps    = r;
        gap     = g;
        start   = 1'b1;
    endtask

    // Compare every queued cycle; optionally re-pulse start after cycles poke1/poke2
    // and scramble the inputs once the transfer is under way.
    task automatic drain(input string tag, input int poke1, input int poke2);
        int n;
        logic [4:0] e;
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            n++;
            e = exp_q.pop_front();
            check($sformatf("%s c%0d", tag, n),
                  {27'd0, out_valid, out, first, done, busy}, {27'd0, e});
            start = (n == poke1) || (n == poke2);
            if (n == 1) begin
                pat     = PAT_W'($urandom);
                reps    = CNT_W'($urandom);
                gap     = CNT_W'($urandom);
                use_def = 1'($urandom);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int done_idx;

        rstn = 1'b0;
        #1;
        check("reset_outs", {27'd0, out_valid, out, first, done, busy}, 32'd0);
        repeat (2) @(negedge clk);
        check("reset_remaining", 32'(dut.remaining), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {27'd0, out_valid, out, first, done, busy}, 32'd0);

        launch(1'b0, 3'b110, 8'd2, 8'd0);
        drain("b2b", 0, 0);

        launch(1'b0, 3'b110, 8'd2, 8'd2);
        drain("gap2", 0, 0);

        launch(1'b0, 3'b101, 8'd0, 8'd5);
        drain("reps0", 0, 0);

        // Pokes land in SEND (cycle 2) and in DONE; the next launch hits the first IDLE cycle.
        launch(1'b0, 3'b101, 8'd2, 8'd1);
        done_idx = exp_q.size() - 1;
        drain("poke", 2, done_idx);
        launch(1'b0, 3'b011, 8'd1, 8'd0);
        drain("after_poke", 0, 0);

        // Asynchronous reset while the second bit is on the line.
        launch(1'b0, 3'b110, 8'd2, 8'd0);
        @(negedge clk);
        check("rst_c1", {27'd0, out_valid, out, first, done, busy}, {27'd0, exp_q.pop_front()});
        start = 1'b0;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_async_drop", {27'd0, out_valid, out, busy}, 32'd0);
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            check("rst_hold", {27'd0, out_valid, out, first, done, busy}, 32'd0);
        end
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_release_idle", {27'd0, out_valid, out, first, done, busy}, 32'd0);
        end

        launch(1'b0, 3'b110, 8'd3, 8'd0);
        drain("post_rst", 0, 0);

        launch(1'b1, 3'b001, 8'd255, 8'd0);
        drain("def255", 0, 0);
        check("def255_remaining", 32'(dut.remaining), 32'd0);

        launch(1'b0, 3'b010, 8'd3, 8'd3);
        drain("gap3", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_gen_pattern_tx.md
# seq_gen_pattern_tx

Serial pattern transmitter: the sending end of the sequence-detector path. On a start pulse it latches a PAT_W-bit pattern, a repeat count and an inter-pattern gap length. It then serializes the pattern MSB-first onto a one-bit stream `out` for the requested number of repetitions and pulses `done` when finished. It sits upstream of the overlapping Moore detectors and drives them with known streams, both back-to-back (overlap) and gapped.

## Interface
- `PAT_W`, default 3: pattern length in bits, ≥ 2.
- `CNT_W`, default 8: width of the repeat and gap counters.
- `PAT_DEF`, default 3'b110: pattern used when `use_def` = 1.

- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous, active-low reset; the only clock is `clk`.
- `start`  in  1  request pulse; sampled only in IDLE.
- `use_def`  in  1  1 = transmit `PAT_DEF` and ignore `pat`.
- `pat`  in  PAT_W  pattern, MSB sent first.
- `reps`  in  CNT_W  number of pattern repetitions, 0..2^CNT_W−1.
- `gap`  in  CNT_W  idle cycles between repetitions, 0 = back-to-back.
- `out`  out  1  serial data; 0 whenever not sending.
- `out_valid`  out  1  high on every cycle `out` carries a pattern bit.
- `first`  out  1  high with the MSB of each repetition.
- `busy`  out  1  high from the cycle after start acceptance through DONE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- All outputs are registered. Reset values: `out`=0, `out_valid`=0, `first`=0, `busy`=0, `done`=0, state IDLE, all counters 0.
- FSM states:
  - IDLE: waiting for `start`.
  - SEND: shifting out one pattern bit per cycle.
  - GAP: idle cycles between repetitions.
  - DONE: one-cycle completion state.
- IDLE transitions:
  - `start`=1 latches `pat` (or `PAT_DEF`), `reps` and `gap`.
  - `reps` ≠ 0: go to SEND, with bit index = PAT_W−1 and remaining = `reps`.
  - `reps` = 0: go to DONE with no data.
- SEND:
  - Drive `out` = shreg[MSB], `out_valid`=1, and `first`=1 when bit index = PAT_W−1.
  - On the last bit, decrement remaining.
  - If remaining becomes 0, go to DONE.
  - Else if `gap` ≠ 0, go to GAP with gap counter = `gap`.
  - Else reload the shift register and stay in SEND. There is no dead cycle, so a 110110… stream is continuous.
- GAP: `out`=0, `out_valid`=0. Decrement the gap counter each cycle; on reaching 0, reload and enter SEND.
- DONE: `done`=1 for one cycle, then return to IDLE. `busy` is still 1 in DONE.
- `start` is ignored while not in IDLE, and inputs change without effect mid-transfer.
- `start` in the same cycle DONE returns to IDLE is ignored, because the FSM is not yet in IDLE. A new start is accepted at the earliest on the first IDLE cycle.
- Counters saturate, never wrap: remaining counts down from ≤ 2^CNT_W−1 and stops at 0.
- `rstn` low at any time, including mid-SEND or mid-GAP, immediately forces all reset values. The transfer is abandoned and `done` is not asserted.

## Timing
- `start` sampled high at edge k: the first pattern bit is on `out` in the cycle after edge k.
- Total cycles from the first bit to `done`: `reps`·PAT_W + (`reps`−1)·`gap`. `done` is high in the cycle following the last bit.
- `reps`=0: `done` is high in the cycle after edge k.
- `busy` rises together with the first `out_valid` (or with `done` when `reps`=0) and falls when DONE is left.
- Throughput: one bit per cycle in SEND; zero-gap repetitions are seamless.

## Structure
- Shared package `seq_pkg` holds:
  - the state enum (IDLE, SEND, GAP, DONE);
  - the constant `PAT_110` = 3'b110;
  - default widths.
- Sub-module `seq_piso`: a PAT_W parallel-load, MSB-first shift register with `load` and `shift` inputs. The FSM and counters live in the top module.

## Test plan
- pat=110, reps=2, gap=0:
  - `out` = 1,1,0,1,1,0 on cycles 1–6 after start;
  - `first` high on cycles 1 and 4;
  - `done` high on cycle 7;
  - a downstream 110 detector counts 2.
- pat=110, reps=2, gap=2: `out`/`out_valid` = 1/1, 1/1, 0/1, 0/0, 0/0, 1/1, 1/1, 0/1, then `done` on cycle 9.
- reps=0: `done` high on cycle 1 after start; `out_valid` never high; `busy` high for that one cycle only.
- `start` pulsed again during SEND and during DONE: both ignored, with exactly one `done` per accepted start; a start on the following IDLE cycle is accepted.
- `rstn` pulled low asynchronously mid-SEND (second bit): `out`, `out_valid`, `busy` drop to 0 before the next edge; no `done`; the next start runs normally.
- use_def=1 with pat=3'b001, reps=255, gap=0: 765 continuous bits of the repeating 110 pattern; the remaining counter ends at 0 without wrap; `done` fires once.
